// File: rtl/alu_pkg.sv
// alu_pkg: shared width constant and opcode encoding for the 16-bit ALU.
package alu_pkg;

  localparam int ALU_W = 16;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_NOR  = 4'b1100,
    ALU_NAND = 4'b1101
  } alu_op_e;

  // True for the opcodes that produce a defined result; the rest yield zero.
  function automatic logic alu_op_known(input logic [3:0] op);
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB,
      ALU_SLT, ALU_NOR, ALU_NAND: alu_op_known = 1'b1;
      default:                    alu_op_known = 1'b0;
    endcase
  endfunction

endpackage : alu_pkg

// File: rtl/alu_core.sv
// alu_core: combinational datapath of the ALU. Produces the next result,
// its zero flag and, when ALU_OVERFLOW_EN is defined, the signed-overflow
// flag for ADD/SUB.
module alu_core
  import alu_pkg::*;
(
  input  logic [3:0]       op,
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  output logic [ALU_W-1:0] result_d,
  output logic             zero_d
`ifdef ALU_OVERFLOW_EN
  , output logic           overflow_d
`endif
);

  logic [ALU_W-1:0] sum;
  logic [ALU_W-1:0] diff;
  logic             a_lt_b;

  // Shared adder/subtractor and a real signed compare so SLT stays correct
  // even when a - b would overflow.
  always_comb begin
    sum    = a + b;
    diff   = a - b;
    a_lt_b = ($signed(a) < $signed(b));
  end

  // Result mux; unknown opcodes deliberately produce zero.
  always_comb begin
    result_d = '0;
    if (alu_op_known(op)) begin
      case (alu_op_e'(op))
        ALU_AND:  result_d = a & b;
        ALU_OR:   result_d = a | b;
        ALU_ADD:  result_d = sum;
        ALU_SUB:  result_d = diff;
        ALU_SLT:  result_d = {{(ALU_W-1){1'b0}}, a_lt_b};
        ALU_NOR:  result_d = ~(a | b);
        ALU_NAND: result_d = ~(a & b);
        default:  result_d = '0;
      endcase
    end
  end

  // Zero flag comes from the exact value that gets registered as result.
  always_comb begin
    zero_d = (result_d == '0);
  end

`ifdef ALU_OVERFLOW_EN
  // Signed overflow: operands agree in sign (ADD) or disagree (SUB) and
  // the result's sign breaks away from operand a.
  always_comb begin
    overflow_d = 1'b0;
    case (op)
      ALU_ADD: overflow_d = (a[ALU_W-1] == b[ALU_W-1]) &&
                            (sum[ALU_W-1] != a[ALU_W-1]);
      ALU_SUB: overflow_d = (a[ALU_W-1] != b[ALU_W-1]) &&
                            (diff[ALU_W-1] != a[ALU_W-1]);
      default: overflow_d = 1'b0;
    endcase
  end
`endif

endmodule : alu_core

// File: rtl/alu.sv
// alu: 16-bit signed ALU with one cycle of latency. Registers result, zero
// and valid_out; result/zero hold when valid_in is low.
// Optional feature macro: ALU_OVERFLOW_EN adds the registered overflow output.
module alu
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [3:0]       op,
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  output logic [ALU_W-1:0] result,
  output logic             zero,
  output logic             valid_out
`ifdef ALU_OVERFLOW_EN
  , output logic           overflow
`endif
);

  logic [ALU_W-1:0] result_d, result_q;
  logic             zero_d, zero_q;
  logic             valid_q;
`ifdef ALU_OVERFLOW_EN
  logic             overflow_d, overflow_q;
`endif

  alu_core u_core (
    .op       (op),
    .a        (a),
    .b        (b),
    .result_d (result_d),
    .zero_d   (zero_d)
`ifdef ALU_OVERFLOW_EN
    , .overflow_d (overflow_d)
`endif
  );

  // Valid pipeline: valid_out is valid_in delayed by one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= 1'b0;
    else     valid_q <= valid_in;
  end

  // Output registers load only on accepted operations, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      zero_q   <= 1'b1;
    end else if (valid_in) begin
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

`ifdef ALU_OVERFLOW_EN
  // Overflow flag travels with result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           overflow_q <= 1'b0;
    else if (valid_in) overflow_q <= overflow_d;
  end

  assign overflow = overflow_q;
`endif

  assign result    = result_q;
  assign zero      = zero_q;
  assign valid_out = valid_q;

endmodule : alu

// File: tb/tb_alu.sv
// tb_alu: directed plus randomized checks of alu against a behavioural
// integer-arithmetic reference model.
module tb_alu;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic [3:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] result;
  logic        zero;
  logic        valid_out;
`ifdef ALU_OVERFLOW_EN
  logic        overflow;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Model of the architectural output state.
  logic [15:0] m_result;
  logic        m_zero;
  logic        m_valid;
  logic        m_ovf;

  alu dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .op        (op),
    .a         (a),
    .b         (b),
    .result    (result),
    .zero      (zero),
    .valid_out (valid_out)
`ifdef ALU_OVERFLOW_EN
    , .overflow (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference: operate on mathematical integers, then truncate to 16 bits.
  function automatic logic [15:0] ref_result(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
    int sx, sy, r;
    sx = $signed(x);
    sy = $signed(y);
    case (o)
      4'b0000: r = int'(x & y);
      4'b0001: r = int'(x | y);
      4'b0010: r = sx + sy;
      4'b0110: r = sx - sy;
      4'b0111: r = (sx < sy) ? 1 : 0;
      4'b1100: r = int'(~(x | y));
      4'b1101: r = int'(~(x & y));
      default: r = 0;
    endcase
    return r[15:0];
  endfunction

  function automatic logic ref_ovf(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
    int sx, sy, r;
    sx = $signed(x);
    sy = $signed(y);
    case (o)
      4'b0010: r = sx + sy;
      4'b0110: r = sx - sy;
      default: r = 0;
    endcase
    return (r > 32767) || (r < -32768);
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".result"}, 32'(result), 32'(m_result));
    check({tag, ".zero"}, 32'(zero), 32'(m_zero));
    check({tag, ".valid_out"}, 32'(valid_out), 32'(m_valid));
`ifdef ALU_OVERFLOW_EN
    check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
`endif
  endtask

  // Drive one cycle's inputs, step the model, sample #1 after the edge.
  task automatic do_op(input string tag, input logic [3:0] o, input logic [15:0] x,
                       input logic [15:0] y, input logic v);
    @(negedge clk);
    op = o; a = x; b = y; valid_in = v;
    if (v) begin
      m_result = ref_result(o, x, y);
      m_zero   = (m_result == 16'd0);
      m_ovf    = ref_ovf(o, x, y);
    end
    m_valid = v;
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  typedef struct {
    string       tag;
    logic [3:0]  o;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] r;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rst = 1'b1; valid_in = 1'b0; op = '0; a = '0; b = '0;
    m_result = '0; m_zero = 1'b1; m_valid = 1'b0; m_ovf = 1'b0;
    #12;
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    vecs.push_back('{"and_7_1",   4'b0000, 16'd7,      16'd1,      16'd1});
    vecs.push_back('{"or_5_2",    4'b0001, 16'd5,      16'd2,      16'd7});
    vecs.push_back('{"nor_5_2",   4'b1100, 16'd5,      16'd2,      16'hFFF8});
    vecs.push_back('{"nand_5_2",  4'b1101, 16'd5,      16'd2,      16'hFFFF});
    vecs.push_back('{"add_4_2",   4'b0010, 16'd4,      16'd2,      16'd6});
    vecs.push_back('{"add_7_1",   4'b0010, 16'd7,      16'd1,      16'd8});
    vecs.push_back('{"sub_5_3",   4'b0110, 16'd5,      16'd3,      16'd2});
    vecs.push_back('{"sub_15_1",  4'b0110, 16'd15,     16'd1,      16'd14});
    vecs.push_back('{"sub_5_5",   4'b0110, 16'd5,      16'd5,      16'd0});
    vecs.push_back('{"add_ovf",   4'b0010, 16'h7FFF,   16'd1,      16'h8000});
    vecs.push_back('{"sub_ovf",   4'b0110, 16'h8000,   16'd1,      16'h7FFF});
    vecs.push_back('{"slt_5_1",   4'b0111, 16'd5,      16'd1,      16'd0});
    vecs.push_back('{"slt_14_15", 4'b0111, 16'd14,     16'd15,     16'd1});
    vecs.push_back('{"slt_m1_1",  4'b0111, 16'hFFFF,   16'd1,      16'd1});
    vecs.push_back('{"slt_max",   4'b0111, 16'h7FFF,   16'h8000,   16'd0});
    vecs.push_back('{"slt_min",   4'b0111, 16'h8000,   16'h7FFF,   16'd1});
    vecs.push_back('{"undef_f",   4'b1111, 16'd3,      16'd4,      16'd0});

    foreach (vecs[i]) begin
      do_op(vecs[i].tag, vecs[i].o, vecs[i].x, vecs[i].y, 1'b1);
      check({vecs[i].tag, ".plan"}, 32'(result), 32'(vecs[i].r));
      check({vecs[i].tag, ".plan_zero"}, 32'(zero), 32'(vecs[i].r == 16'd0));
    end

`ifdef ALU_OVERFLOW_EN
    do_op("ovf_plan", 4'b0010, 16'h7FFF, 16'd1, 1'b1);
    check("ovf_plan.flag", 32'(overflow), 32'd1);
`endif

    // Handshake: load a nonzero value, then hold through two idle cycles.
    do_op("hs_load", 4'b0010, 16'd100, 16'd23, 1'b1);
    do_op("hs_idle0", 4'b0110, 16'd9, 16'd9, 1'b0);
    check("hs_idle0.hold", 32'(result), 32'd123);
    do_op("hs_idle1", 4'b0000, 16'd0, 16'd0, 1'b0);
    check("hs_idle1.hold", 32'(result), 32'd123);
    do_op("hs_resume", 4'b0001, 16'h0F00, 16'h00F0, 1'b1);
    check("hs_resume.val", 32'(result), 32'h0FF0);

    // Randomized stream with random valid gaps and all 16 opcodes.
    for (int i = 0; i < 400; i++) begin
      logic [3:0]  ro;
      logic [15:0] rx, ry;
      logic        rv;
      ro = 4'($urandom_range(0, 15));
      rx = 16'($urandom);
      ry = 16'($urandom);
      case ($urandom_range(0, 7))
        0: ry = rx;
        1: rx = 16'h7FFF;
        2: rx = 16'h8000;
        default: ;
      endcase
      rv = ($urandom_range(0, 3) != 0);
      do_op("rand", ro, rx, ry, rv);
    end

    // Reset mid-stream, between edges: outputs clear without a clock edge.
    do_op("pre_rst", 4'b0001, 16'h1234, 16'h0001, 1'b1);
    @(negedge clk);
    op = 4'b0010; a = 16'h7FFF; b = 16'd1; valid_in = 1'b1;
    #2;
    rst = 1'b1;
    m_result = '0; m_zero = 1'b1; m_valid = 1'b0; m_ovf = 1'b0;
    #1;
    check_outputs("rst_async");
    repeat (2) @(posedge clk);
    #1;
    check_outputs("rst_held");
    @(negedge clk);
    rst = 1'b0;
    do_op("post_rst", 4'b0110, 16'd20, 16'd7, 1'b1);
    check("post_rst.val", 32'(result), 32'd13);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule : tb_alu
